// File: rtl/cl2_pl_pkg.sv
// Shared pipeline types for the CL2 EXU writeback path.
// Request record, source encodings and small index helpers.
package cl2_pl_pkg;

  localparam int CL2_XLEN          = 32;
  localparam int CL2_REGFILE_WIDTH = 5;

  localparam logic WBCK_SRC_ALU = 1'b0;
  localparam logic WBCK_SRC_LSU = 1'b1;

  typedef struct packed {
    logic [CL2_REGFILE_WIDTH-1:0] idx;
    logic [CL2_XLEN-1:0]          dat;
    logic                         err;
  } wbck_req_t;

  function automatic logic wbck_is_x0(input logic [CL2_REGFILE_WIDTH-1:0] idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/cl2_pl_exu_wbck_arb.sv
// Writeback source arbiter: LSU has priority, ALU is granted after STARV_MAX
// consecutive losing cycles. Grants are combinational from valids and the counter.
module cl2_pl_exu_wbck_arb
  import cl2_pl_pkg::*;
#(
  parameter int unsigned STARV_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic alu_vld_i,
  input  logic lsu_vld_i,
  output logic alu_gnt_o,
  output logic lsu_gnt_o,
  output logic src_o
);

  localparam int unsigned CW = (STARV_MAX > 1) ? $clog2(STARV_MAX + 1) : 1;

  logic [CW-1:0] starv_q;
  logic [CW-1:0] starv_d;
  logic          starved;

  assign starved = (starv_q == CW'(STARV_MAX));

  always_comb begin
    alu_gnt_o = alu_vld_i & (~lsu_vld_i | starved);
    lsu_gnt_o = lsu_vld_i & ~alu_gnt_o;
    src_o     = lsu_gnt_o ? WBCK_SRC_LSU : WBCK_SRC_ALU;
  end

  // Only a pending-and-losing ALU advances the count; anything else clears it.
  always_comb begin
    starv_d = '0;
    if (alu_vld_i && lsu_gnt_o) begin
      starv_d = starv_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starv_q <= '0;
    end else begin
      starv_q <= starv_d;
    end
  end

endmodule

// File: rtl/cl2_pl_exu_wbck.sv
// EXU writeback stage: arbitrates ALU/LSU results into a 1-entry write stage
// feeding the regfile. Optional operand bypass enabled by CL2_WBCK_FWD_EN.
module cl2_pl_exu_wbck
  import cl2_pl_pkg::*;
#(
  parameter int unsigned XLEN      = CL2_XLEN,
  parameter int unsigned REG_AW    = CL2_REGFILE_WIDTH,
  parameter int unsigned STARV_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              alu_vld_i,
  output logic              alu_rdy_o,
  input  logic [REG_AW-1:0] alu_idx_i,
  input  logic [XLEN-1:0]   alu_dat_i,
  input  logic              lsu_vld_i,
  output logic              lsu_rdy_o,
  input  logic [REG_AW-1:0] lsu_idx_i,
  input  logic [XLEN-1:0]   lsu_dat_i,
  input  logic              lsu_err_i,
  output logic              rd_wen_o,
  output logic [REG_AW-1:0] rd_wr_idx_o,
  output logic [XLEN-1:0]   rd_wr_dat_o,
  output logic              lsu_err_o,
  input  logic [REG_AW-1:0] rs1_idx_i,
  input  logic [REG_AW-1:0] rs2_idx_i,
  input  logic [XLEN-1:0]   rs1_dat_i,
  input  logic [XLEN-1:0]   rs2_dat_i,
  output logic [XLEN-1:0]   rs1_dat_o,
  output logic [XLEN-1:0]   rs2_dat_o
);

  logic      alu_gnt;
  logic      lsu_gnt;
  logic      src_sel;
  wbck_req_t req_alu;
  wbck_req_t req_lsu;
  wbck_req_t req_win;

  logic              wen_q, wen_d;
  logic              err_q, err_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   dat_q, dat_d;

  cl2_pl_exu_wbck_arb #(
    .STARV_MAX (STARV_MAX)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .alu_vld_i (alu_vld_i),
    .lsu_vld_i (lsu_vld_i),
    .alu_gnt_o (alu_gnt),
    .lsu_gnt_o (lsu_gnt),
    .src_o     (src_sel)
  );

  assign alu_rdy_o = alu_gnt;
  assign lsu_rdy_o = lsu_gnt;

  always_comb begin
    req_alu     = '0;
    req_alu.idx = CL2_REGFILE_WIDTH'(alu_idx_i);
    req_alu.dat = CL2_XLEN'(alu_dat_i);
    req_alu.err = 1'b0;
    req_lsu     = '0;
    req_lsu.idx = CL2_REGFILE_WIDTH'(lsu_idx_i);
    req_lsu.dat = CL2_XLEN'(lsu_dat_i);
    req_lsu.err = lsu_err_i;
    req_win     = (src_sel == WBCK_SRC_LSU) ? req_lsu : req_alu;
  end

  // A faulted load leaves idx/dat untouched; an x0 write is accepted but not enabled.
  always_comb begin
    wen_d = 1'b0;
    err_d = 1'b0;
    idx_d = idx_q;
    dat_d = dat_q;
    if (alu_gnt || lsu_gnt) begin
      if (req_win.err) begin
        err_d = 1'b1;
      end else begin
        idx_d = REG_AW'(req_win.idx);
        dat_d = XLEN'(req_win.dat);
        wen_d = ~wbck_is_x0(req_win.idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wen_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else begin
      wen_q <= wen_d;
      err_q <= err_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
    end
  end

  assign rd_wen_o    = wen_q;
  assign lsu_err_o   = err_q;
  assign rd_wr_idx_o = idx_q;
  assign rd_wr_dat_o = dat_q;

`ifdef CL2_WBCK_FWD_EN
  // Covers the regfile write and read landing in the same cycle.
  assign rs1_dat_o = (wen_q && (idx_q == rs1_idx_i) && (rs1_idx_i != '0)) ? dat_q : rs1_dat_i;
  assign rs2_dat_o = (wen_q && (idx_q == rs2_idx_i) && (rs2_idx_i != '0)) ? dat_q : rs2_dat_i;
`else
  logic unused_fwd_idx;
  assign unused_fwd_idx = ^{rs1_idx_i, rs2_idx_i};
  assign rs1_dat_o      = rs1_dat_i;
  assign rs2_dat_o      = rs2_dat_i;
`endif

endmodule

// File: tb/tb_cl2_pl_exu_wbck.sv
// Self-checking bench for cl2_pl_exu_wbck: directed scenarios plus a randomized
// run against a behavioural model. Bypass expectations follow CL2_WBCK_FWD_EN.
module tb_cl2_pl_exu_wbck;

  localparam int STARV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_vld, alu_rdy, lsu_vld, lsu_rdy, lsu_err, rd_wen, err_o;
  logic [4:0]  alu_idx, lsu_idx, rd_idx, rs1_idx, rs2_idx;
  logic [31:0] alu_dat, lsu_dat, rd_dat, rs1_dat, rs2_dat, rs1_out, rs2_out;

  int errs   = 0;
  int checks = 0;

  // Behavioural model state: committed outputs plus what the next edge will produce.
  int          losses, losses_n;
  logic        e_alu_rdy, e_lsu_rdy;
  logic        m_wen, m_err, n_wen, n_err;
  logic [4:0]  m_idx, n_idx;
  logic [31:0] m_dat, n_dat;

  always #5 clk = ~clk;

  cl2_pl_exu_wbck #(.XLEN(32), .REG_AW(5), .STARV_MAX(STARV)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .alu_vld_i   (alu_vld),
    .alu_rdy_o   (alu_rdy),
    .alu_idx_i   (alu_idx),
    .alu_dat_i   (alu_dat),
    .lsu_vld_i   (lsu_vld),
    .lsu_rdy_o   (lsu_rdy),
    .lsu_idx_i   (lsu_idx),
    .lsu_dat_i   (lsu_dat),
    .lsu_err_i   (lsu_err),
    .rd_wen_o    (rd_wen),
    .rd_wr_idx_o (rd_idx),
    .rd_wr_dat_o (rd_dat),
    .lsu_err_o   (err_o),
    .rs1_idx_i   (rs1_idx),
    .rs2_idx_i   (rs2_idx),
    .rs1_dat_i   (rs1_dat),
    .rs2_dat_i   (rs2_dat),
    .rs1_dat_o   (rs1_out),
    .rs2_dat_o   (rs2_out)
  );

  task automatic model_reset();
    losses = 0; losses_n = 0;
    m_wen = 1'b0; m_err = 1'b0; m_idx = '0; m_dat = '0;
    n_wen = 1'b0; n_err = 1'b0; n_idx = '0; n_dat = '0;
    e_alu_rdy = 1'b0; e_lsu_rdy = 1'b0;
  endtask

  function automatic logic [31:0] fwd_exp(input logic [4:0] ri, input logic [31:0] rd);
`ifdef CL2_WBCK_FWD_EN
    if (m_wen && m_idx == ri && ri != 5'd0) return m_dat;
`endif
    return rd;
  endfunction

  // Drive one cycle's requests after the falling edge and predict the outcome.
  task automatic cyc(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                     input logic lv, input logic [4:0] li, input logic [31:0] ld,
                     input logic le);
    bit alu_win, lsu_win;
    @(negedge clk);
    alu_vld = av; alu_idx = ai; alu_dat = ad;
    lsu_vld = lv; lsu_idx = li; lsu_dat = ld; lsu_err = le;
    #1;
    alu_win   = av && (!lv || losses == STARV);
    lsu_win   = lv && !alu_win;
    e_alu_rdy = alu_win;
    e_lsu_rdy = lsu_win;
    losses_n  = (av && !alu_win) ? losses + 1 : 0;
    n_wen = 1'b0; n_err = 1'b0; n_idx = m_idx; n_dat = m_dat;
    if (alu_win) begin
      n_idx = ai; n_dat = ad; n_wen = (ai != 5'd0);
    end else if (lsu_win) begin
      if (le) n_err = 1'b1;
      else begin n_idx = li; n_dat = ld; n_wen = (li != 5'd0); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    losses = losses_n;
    m_wen = n_wen; m_err = n_err; m_idx = n_idx; m_dat = n_dat;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_vld = 0; alu_idx = 0; alu_dat = 0;
    lsu_vld = 0; lsu_idx = 0; lsu_dat = 0; lsu_err = 0;
    rs1_idx = 0; rs2_idx = 0; rs1_dat = 0; rs2_dat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_wen !== 1'b0) begin errs++; $display("FAIL reset_wen got=%b exp=0", rd_wen); end
    checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err_o); end
    checks++; if (rd_idx !== 5'd0) begin errs++; $display("FAIL reset_idx got=%0d exp=0", rd_idx); end
    checks++; if (rd_dat !== 32'd0) begin errs++; $display("FAIL reset_dat got=%h exp=0", rd_dat); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_only();
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++; if (alu_rdy !== 1'b1 || lsu_rdy !== 1'b0) begin
      errs++; $display("FAIL alu_only_rdy got=%b%b exp=10", alu_rdy, lsu_rdy); end
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_idx !== 5'd5 || rd_dat !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL alu_only_wr got=%b/%0d/%h exp=1/5/deadbeef", rd_wen, rd_idx, rd_dat); end
    idle(); tick();
    checks++; if (rd_wen !== 1'b0 || rd_idx !== 5'd5 || rd_dat !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL no_grant_hold got=%b/%0d/%h exp=0/5/deadbeef", rd_wen, rd_idx, rd_dat); end
  endtask

  task automatic test_starvation(input string tag);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 5'd10, 32'hA000_0000 + 32'(k), 1'b1, 5'd11, 32'hB000_0000 + 32'(k), 1'b0);
      checks++;
      if (alu_rdy !== (k == 4) || lsu_rdy !== (k != 4)) begin
        errs++; $display("FAIL %s_cyc%0d got alu=%b lsu=%b exp alu=%b", tag, k, alu_rdy, lsu_rdy, (k == 4));
      end
      tick();
      checks++;
      if (rd_wen !== 1'b1 || rd_idx !== ((k == 4) ? 5'd10 : 5'd11) || rd_dat[3:0] !== 4'(k)) begin
        errs++; $display("FAIL %s_wr%0d got=%b/%0d/%h", tag, k, rd_wen, rd_idx, rd_dat);
      end
    end
    idle(); tick();
  endtask

  task automatic test_x0();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1, 1'b0);
    checks++; if (lsu_rdy !== 1'b1) begin errs++; $display("FAIL x0_rdy got=%b exp=1", lsu_rdy); end
    tick();
    checks++; if (rd_wen !== 1'b0 || err_o !== 1'b0) begin
      errs++; $display("FAIL x0_wr got wen=%b err=%b exp 0/0", rd_wen, err_o); end
  endtask

  task automatic test_lsu_err();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE_F00D, 1'b1);
    checks++; if (lsu_rdy !== 1'b1) begin errs++; $display("FAIL err_rdy got=%b exp=1", lsu_rdy); end
    tick();
    checks++; if (rd_wen !== 1'b0 || err_o !== 1'b1) begin
      errs++; $display("FAIL err_pulse got wen=%b err=%b exp 0/1", rd_wen, err_o); end
    idle(); tick();
    checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL err_one_cycle got=%b exp=0", err_o); end
  endtask

  task automatic test_forward();
    logic [31:0] e1;
    cyc(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    rs1_idx = 5'd3; rs1_dat = 32'h0; rs2_idx = 5'd0; rs2_dat = 32'h1234_5678;
    #1;
`ifdef CL2_WBCK_FWD_EN
    e1 = 32'h55;
`else
    e1 = 32'h0;
`endif
    checks++; if (rs1_out !== e1) begin errs++; $display("FAIL fwd_rs1 got=%h exp=%h", rs1_out, e1); end
    checks++; if (rs2_out !== 32'h1234_5678) begin
      errs++; $display("FAIL fwd_rs2_x0 got=%h exp=12345678", rs2_out); end
    idle(); tick();
    #1;
    checks++; if (rs1_out !== 32'h0) begin errs++; $display("FAIL fwd_after_wen got=%h exp=0", rs1_out); end
    rs1_idx = 0; rs2_idx = 0; rs1_dat = 0; rs2_dat = 0;
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 5'd9, 32'h1, 1'b1, 5'd12, 32'h2, 1'b0); tick();
    cyc(1'b1, 5'd9, 32'h1, 1'b1, 5'd12, 32'h2, 1'b0); tick();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h77, 1'b0); tick();
    checks++; if (rd_wen !== 1'b1) begin errs++; $display("FAIL pre_reset_wen got=%b exp=1", rd_wen); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_wen !== 1'b0 || rd_idx !== 5'd0 || rd_dat !== 32'd0) begin
      errs++; $display("FAIL async_reset got=%b/%0d/%h exp=0/0/0", rd_wen, rd_idx, rd_dat); end
    model_reset();
    alu_vld = 0; lsu_vld = 0;
    @(negedge clk);
    rst_n = 1'b1;
    test_starvation("post_reset");
  endtask

  task automatic test_random();
    logic [31:0] r1, r2;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
          ($urandom_range(0, 5) == 0));
      checks++;
      if (alu_rdy !== e_alu_rdy || lsu_rdy !== e_lsu_rdy) begin
        errs++; $display("FAIL rnd_rdy n=%0d got=%b%b exp=%b%b", n, alu_rdy, lsu_rdy, e_alu_rdy, e_lsu_rdy);
      end
      tick();
      checks++;
      if (rd_wen !== m_wen || err_o !== m_err) begin
        errs++; $display("FAIL rnd_flags n=%0d got wen=%b err=%b exp %b/%b", n, rd_wen, err_o, m_wen, m_err);
      end
      if (m_wen) begin
        checks++;
        if (rd_idx !== m_idx || rd_dat !== m_dat) begin
          errs++; $display("FAIL rnd_wr n=%0d got=%0d/%h exp=%0d/%h", n, rd_idx, rd_dat, m_idx, m_dat);
        end
      end
      rs1_idx = ($urandom_range(0, 1) != 0) ? m_idx : 5'($urandom_range(0, 31));
      rs2_idx = 5'($urandom_range(0, 31));
      rs1_dat = $urandom; rs2_dat = $urandom;
      #1;
      r1 = fwd_exp(rs1_idx, rs1_dat);
      r2 = fwd_exp(rs2_idx, rs2_dat);
      checks++;
      if (rs1_out !== r1 || rs2_out !== r2) begin
        errs++; $display("FAIL rnd_fwd n=%0d got=%h/%h exp=%h/%h", n, rs1_out, rs2_out, r1, r2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_starvation("starv");
    test_x0();
    test_lsu_err();
    test_forward();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
